// File: rtl/regfile_2r1w_sweep_pkg.sv
// Shared definitions for the swept-reset 2-read/1-write register file:
// sweep FSM states, address-width helper and feature defaults.
package regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    localparam bit ZERO_REG_DEFAULT = 1'b1;
    localparam bit BYPASS_DEFAULT   = 1'b1;

    // A single-entry file still needs one address bit to index the array.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/regfile_2r1w_sweep_if.sv
// Decode/writeback-facing bus of the register file: one write port,
// two read ports and the busy flag raised while the clear sweep runs.
interface regfile_2r1w_sweep_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
);
    import regfile_pkg::*;

    localparam int ADDR_W = addr_w(DEPTH);

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;
    logic [ADDR_W-1:0] rd_addr0;
    logic [WIDTH-1:0]  rd_data0;
    logic [ADDR_W-1:0] rd_addr1;
    logic [WIDTH-1:0]  rd_data1;
    logic              busy;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr0, rd_addr1,
        input  rd_data0, rd_data1, busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr0, rd_addr1,
        output rd_data0, rd_data1, busy
    );

endinterface

// File: rtl/regfile_2r1w_sweep_read_port.sv
// One combinational read port: busy-zero, hard-wired zero register,
// write bypass and array data, in that order of priority.
module regfile_read_port import regfile_pkg::*; #(
    parameter int WIDTH    = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = ZERO_REG_DEFAULT
) (
    input  logic              busy_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic [WIDTH-1:0]  mem_data_i,
    input  logic              byp_valid_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]  wr_data_i,
    output logic [WIDTH-1:0]  rd_data_o
);

    always_comb begin
        // NOTE: assigning a default before the if-chain keeps every path driven, so no latch is inferred.
        rd_data_o = mem_data_i;
        if (busy_i) begin
            rd_data_o = '0;
        end else if (ZERO_REG && (rd_addr_i == '0)) begin
            rd_data_o = '0;
        end else if (byp_valid_i && (wr_addr_i == rd_addr_i)) begin
            rd_data_o = wr_data_i;
        end
    end

endmodule

// File: rtl/regfile_2r1w_sweep.sv
// Parametrised 2R1W register file; storage is cleared by a one-entry-per-cycle
// sweep after reset so the array itself needs no reset and can map to RAM.
module regfile_2r1w_sweep import regfile_pkg::*; #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter bit ZERO_REG = ZERO_REG_DEFAULT,
    parameter bit BYPASS   = BYPASS_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_2r1w_sweep_if.slave  bus
);

    localparam int                ADDR_W = addr_w(DEPTH);
    localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(DEPTH - 1);

    state_e            state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [WIDTH-1:0]  mem [DEPTH];

    logic              busy;
    logic              write_drop;
    logic              byp_valid;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [WIDTH-1:0]  mem_wdata;

    // Reset restarts the sweep from entry 0 regardless of where it was.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
        end else if (state_q == CLEAR) begin
            ptr_q <= ptr_q + ADDR_W'(1);
            if (ptr_q == LAST) begin
                state_q <= RUN;
            end
        end
    end

    assign busy       = (state_q == CLEAR);
    assign bus.busy   = busy;
    assign write_drop = ZERO_REG && (bus.wr_addr == '0);

    // The sweep and the functional write share the single array write port.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = ptr_q;
        mem_wdata = '0;
        if (!reset) begin
            if (busy) begin
                mem_we = 1'b1;
            end else if (bus.wr_en && !write_drop) begin
                mem_we    = 1'b1;
                mem_waddr = bus.wr_addr;
                mem_wdata = bus.wr_data;
            end
        end
    end

    // NOTE: the array is deliberately not reset; the sweep clears it so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign byp_valid = BYPASS && !busy && bus.wr_en && !write_drop;

    regfile_read_port #(
        .WIDTH    (WIDTH),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_rd0 (
        .busy_i      (busy),
        .rd_addr_i   (bus.rd_addr0),
        .mem_data_i  (mem[bus.rd_addr0]),
        .byp_valid_i (byp_valid),
        .wr_addr_i   (bus.wr_addr),
        .wr_data_i   (bus.wr_data),
        .rd_data_o   (bus.rd_data0)
    );

    regfile_read_port #(
        .WIDTH    (WIDTH),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_rd1 (
        .busy_i      (busy),
        .rd_addr_i   (bus.rd_addr1),
        .mem_data_i  (mem[bus.rd_addr1]),
        .byp_valid_i (byp_valid),
        .wr_addr_i   (bus.wr_addr),
        .wr_data_i   (bus.wr_data),
        .rd_data_o   (bus.rd_data1)
    );

endmodule

// File: tb/tb_regfile_2r1w_sweep.sv
// Bench for regfile_2r1w_sweep: three configurations (32x32 zero+bypass,
// 32x32 plain, 8x4 zero+bypass) compared against an array-based reference.
module tb_regfile_2r1w_sweep;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst1, rst2;

    regfile_2r1w_sweep_if #(.WIDTH(32), .DEPTH(32)) bus0 ();
    regfile_2r1w_sweep_if #(.WIDTH(32), .DEPTH(32)) bus1 ();
    regfile_2r1w_sweep_if #(.WIDTH(8),  .DEPTH(4))  bus2 ();

    regfile_2r1w_sweep #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1'b1), .BYPASS(1'b1))
        u_dut0 (.clk(clk), .reset(rst0), .bus(bus0));
    regfile_2r1w_sweep #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1'b0), .BYPASS(1'b0))
        u_dut1 (.clk(clk), .reset(rst1), .bus(bus1));
    regfile_2r1w_sweep #(.WIDTH(8), .DEPTH(4), .ZERO_REG(1'b1), .BYPASS(1'b1))
        u_dut2 (.clk(clk), .reset(rst2), .bus(bus2));

    int checks   = 0;
    int failures = 0;

    // Reference contents per instance; instance 2 uses entries 0..3, low byte only.
    logic [31:0] mdl [3][32];

    function automatic int dep(input int i);
        return (i == 2) ? 4 : 32;
    endfunction

    function automatic bit zr(input int i);
        return (i != 1);
    endfunction

    function automatic bit bp(input int i);
        return (i != 1);
    endfunction

    function automatic logic [31:0] mask(input int i);
        return (i == 2) ? 32'h0000_00FF : 32'hFFFF_FFFF;
    endfunction

    // Value a read port must show in RUN, given this cycle's write port.
    function automatic logic [31:0] exp_rd(input int i, input int ra, input bit we,
                                           input int wa, input logic [31:0] wd);
        if (zr(i) && ra == 0) return 32'h0;
        if (bp(i) && we && wa == ra && !(zr(i) && wa == 0)) return wd & mask(i);
        return mdl[i][ra];
    endfunction

    task automatic mdl_commit(input int i, input bit we, input int wa, input logic [31:0] wd);
        if (we && !(zr(i) && wa == 0)) mdl[i][wa] = wd & mask(i);
    endtask

    task automatic mdl_clear(input int i);
        for (int a = 0; a < 32; a++) mdl[i][a] = 32'h0;
    endtask

    task automatic drive(input int i, input bit we, input int wa, input logic [31:0] wd,
                         input int ra0, input int ra1);
        case (i)
            0: begin
                bus0.wr_en = we; bus0.wr_addr = 5'(wa); bus0.wr_data = wd;
                bus0.rd_addr0 = 5'(ra0); bus0.rd_addr1 = 5'(ra1);
            end
            1: begin
                bus1.wr_en = we; bus1.wr_addr = 5'(wa); bus1.wr_data = wd;
                bus1.rd_addr0 = 5'(ra0); bus1.rd_addr1 = 5'(ra1);
            end
            default: begin
                bus2.wr_en = we; bus2.wr_addr = 2'(wa); bus2.wr_data = 8'(wd);
                bus2.rd_addr0 = 2'(ra0); bus2.rd_addr1 = 2'(ra1);
            end
        endcase
    endtask

    task automatic observe(input int i, output logic [31:0] d0, output logic [31:0] d1,
                           output logic b);
        case (i)
            0: begin d0 = bus0.rd_data0; d1 = bus0.rd_data1; b = bus0.busy; end
            1: begin d0 = bus1.rd_data0; d1 = bus1.rd_data1; b = bus1.busy; end
            default: begin
                d0 = {24'h0, bus2.rd_data0}; d1 = {24'h0, bus2.rd_data1}; b = bus2.busy;
            end
        endcase
    endtask

    // Drive one cycle, sample the combinational reads, then let the edge commit.
    task automatic cycle(input int i, input bit we, input int wa, input logic [31:0] wd,
                         input int ra0, input int ra1,
                         output logic [31:0] d0, output logic [31:0] d1);
        logic b;
        drive(i, we, wa, wd, ra0, ra1);
        #1;
        observe(i, d0, d1, b);
        @(posedge clk);
        mdl_commit(i, we, wa, wd);
        #1;
        drive(i, 1'b0, 0, 32'h0, ra0, ra1);
    endtask

    task automatic test_reset();
        int          cnt [3];
        logic        bz [3];
        logic [31:0] d0, d1;
        logic        b;
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(i, 1'b0, 0, 32'h0, 0, 0);
            cnt[i] = 0;
        end
        @(posedge clk); #1;
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
        for (int c = 0; c < 40; c++) begin
            for (int i = 0; i < 3; i++) begin
                observe(i, d0, d1, b);
                bz[i] = (b === 1'b1);
                if (bz[i]) begin
                    cnt[i]++;
                    if (i == 0)
                        drive(i, 1'b1, 5, 32'hDEAD, $urandom_range(31), $urandom_range(31));
                    else
                        drive(i, 1'b1, $urandom_range(dep(i) - 1), $urandom,
                              $urandom_range(dep(i) - 1), $urandom_range(dep(i) - 1));
                end else begin
                    drive(i, 1'b0, 0, 32'h0, 0, 0);
                end
            end
            #1;
            for (int i = 0; i < 3; i++) begin
                if (bz[i]) begin
                    observe(i, d0, d1, b);
                    checks++;
                    if (d0 !== 32'h0 || d1 !== 32'h0) begin
                        failures++;
                        $display("FAIL reset_busy_read inst=%0d got=%h/%h exp=0", i, d0, d1);
                    end
                end
            end
            @(posedge clk); #1;
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (cnt[i] != dep(i)) begin
                failures++;
                $display("FAIL reset_busy_cycles inst=%0d got=%0d exp=%0d", i, cnt[i], dep(i));
            end
            mdl_clear(i);
        end
        cycle(0, 1'b0, 0, 32'h0, 5, 17, d0, d1);
        checks++;
        if (d0 !== exp_rd(0, 5, 1'b0, 0, 32'h0) || d1 !== exp_rd(0, 17, 1'b0, 0, 32'h0)) begin
            failures++;
            $display("FAIL reset_addr5_ignored got=%h/%h exp=0/0", d0, d1);
        end
        for (int i = 1; i < 3; i++) begin
            int a0 = $urandom_range(dep(i) - 1);
            int a1 = $urandom_range(dep(i) - 1);
            cycle(i, 1'b0, 0, 32'h0, a0, a1, d0, d1);
            checks++;
            if (d0 !== 32'h0 || d1 !== 32'h0) begin
                failures++;
                $display("FAIL reset_cleared inst=%0d got=%h/%h exp=0", i, d0, d1);
            end
        end
    endtask

    task automatic test_basic();
        logic [31:0] d0, d1, e0, e1;
        cycle(0, 1'b1, 7, 32'h1234_5678, 0, 0, d0, d1);
        cycle(0, 1'b1, 31, 32'hCAFE_F00D, 0, 0, d0, d1);
        e0 = exp_rd(0, 7, 1'b0, 0, 32'h0);
        e1 = exp_rd(0, 31, 1'b0, 0, 32'h0);
        cycle(0, 1'b0, 0, 32'h0, 7, 31, d0, d1);
        checks++;
        if (d0 !== e0) begin
            failures++; $display("FAIL basic_rd0 got=%h exp=%h", d0, e0);
        end
        checks++;
        if (d1 !== e1) begin
            failures++; $display("FAIL basic_rd1 got=%h exp=%h", d1, e1);
        end
    endtask

    task automatic test_zero_reg();
        logic [31:0] d0, d1, e0;
        for (int i = 0; i < 2; i++) begin
            e0 = exp_rd(i, 0, 1'b1, 0, 32'hFFFF_FFFF);
            cycle(i, 1'b1, 0, 32'hFFFF_FFFF, 0, 0, d0, d1);
            checks++;
            if (d0 !== e0) begin
                failures++; $display("FAIL zero_same_cycle inst=%0d got=%h exp=%h", i, d0, e0);
            end
            e0 = exp_rd(i, 0, 1'b0, 0, 32'h0);
            cycle(i, 1'b0, 0, 32'h0, 0, 0, d0, d1);
            checks++;
            if (d0 !== e0) begin
                failures++; $display("FAIL zero_next_cycle inst=%0d got=%h exp=%h", i, d0, e0);
            end
        end
    endtask

    task automatic test_bypass();
        logic [31:0] d0, d1, e;
        for (int i = 0; i < 2; i++) begin
            cycle(i, 1'b1, 3, 32'h11, 0, 0, d0, d1);
            e = exp_rd(i, 3, 1'b1, 3, 32'h22);
            cycle(i, 1'b1, 3, 32'h22, 3, 3, d0, d1);
            checks++;
            if (d0 !== e || d1 !== e) begin
                failures++; $display("FAIL bypass_same inst=%0d got=%h/%h exp=%h", i, d0, d1, e);
            end
            e = exp_rd(i, 3, 1'b0, 0, 32'h0);
            cycle(i, 1'b0, 0, 32'h0, 3, 3, d0, d1);
            checks++;
            if (d0 !== e || d1 !== e) begin
                failures++; $display("FAIL bypass_next inst=%0d got=%h/%h exp=%h", i, d0, d1, e);
            end
        end
    endtask

    task automatic test_small();
        logic [31:0] d0, d1, e;
        cycle(2, 1'b1, 3, 32'h5A, 0, 0, d0, d1);
        e = exp_rd(2, 3, 1'b0, 0, 32'h0);
        cycle(2, 1'b0, 0, 32'h0, 3, 3, d0, d1);
        checks++;
        if (d0 !== e || d1 !== e) begin
            failures++; $display("FAIL small_rd3 got=%h/%h exp=%h", d0, d1, e);
        end
        e = exp_rd(2, 0, 1'b1, 0, 32'h77);
        cycle(2, 1'b1, 0, 32'h77, 0, 3, d0, d1);
        checks++;
        if (d0 !== e) begin
            failures++; $display("FAIL small_zero_same got=%h exp=%h", d0, e);
        end
        e = exp_rd(2, 0, 1'b0, 0, 32'h0);
        cycle(2, 1'b0, 0, 32'h0, 0, 3, d0, d1);
        checks++;
        if (d0 !== e) begin
            failures++; $display("FAIL small_zero_next got=%h exp=%h", d0, e);
        end
    endtask

    task automatic test_random();
        logic [31:0] d0, d1, e0, e1, wd;
        int          wa, ra0, ra1;
        bit          we;
        for (int i = 0; i < 3; i++) begin
            for (int n = 0; n < 300; n++) begin
                we  = $urandom_range(1) == 1;
                wa  = $urandom_range(dep(i) - 1);
                wd  = $urandom;
                ra0 = ($urandom_range(3) == 0) ? wa : $urandom_range(dep(i) - 1);
                ra1 = ($urandom_range(3) == 0) ? ra0 : $urandom_range(dep(i) - 1);
                e0  = exp_rd(i, ra0, we, wa, wd);
                e1  = exp_rd(i, ra1, we, wa, wd);
                cycle(i, we, wa, wd, ra0, ra1, d0, d1);
                checks++;
                if (d0 !== e0 || d1 !== e1) begin
                    failures++;
                    $display("FAIL random inst=%0d n=%0d ra=%0d/%0d got=%h/%h exp=%h/%h",
                             i, n, ra0, ra1, d0, d1, e0, e1);
                end
            end
        end
    endtask

    task automatic test_reset_mid_sweep();
        logic [31:0] d0, d1, e;
        int          cnt;
        bit          stayed_busy;
        cycle(0, 1'b1, 20, 32'hAA, 0, 0, d0, d1);
        e = exp_rd(0, 20, 1'b0, 0, 32'h0);
        cycle(0, 1'b0, 0, 32'h0, 20, 20, d0, d1);
        checks++;
        if (d0 !== e) begin
            failures++; $display("FAIL mid_sweep_prefill got=%h exp=%h", d0, e);
        end
        rst0 = 1'b1;
        @(posedge clk); #1;
        rst0 = 1'b0;
        stayed_busy = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (bus0.busy !== 1'b1) stayed_busy = 1'b0;
            @(posedge clk); #1;
        end
        checks++;
        if (!stayed_busy) begin
            failures++; $display("FAIL mid_sweep_early_busy got=0 exp=1");
        end
        rst0 = 1'b1;
        @(posedge clk); #1;
        rst0 = 1'b0;
        cnt = 0;
        for (int c = 0; c < 60; c++) begin
            if (bus0.busy !== 1'b1) break;
            cnt++;
            @(posedge clk); #1;
        end
        checks++;
        if (cnt != 32) begin
            failures++; $display("FAIL mid_sweep_busy_cycles got=%0d exp=32", cnt);
        end
        mdl_clear(0);
        e = exp_rd(0, 20, 1'b0, 0, 32'h0);
        cycle(0, 1'b0, 0, 32'h0, 20, 7, d0, d1);
        checks++;
        if (d0 !== e || d1 !== 32'h0) begin
            failures++; $display("FAIL mid_sweep_cleared got=%h/%h exp=%h/0", d0, d1, e);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_zero_reg();
        test_bypass();
        test_small();
        test_random();
        test_reset_mid_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
